rr_arbiter_8: RTL and testbench

//  Round-robin arbiter sharing one resource among NUM_REQ requesters.

---
 rtl/rr_arbiter_8.sv | 141 ++++++++++++++
 tb/tb_rr_arbiter_8.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with a registered one-hot grant and its binary index.
// Define HOLD_TIMEOUT_EN to revoke a grant that has been held for MAX_HOLD cycles.
module rr_arbiter_8 #(
   parameter int NUM_REQ  = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid,
   output logic               timeout
);

   typedef enum logic {
      IDLE,
      GRANT
   } stateT;

   stateT              state;
   stateT              stateNext;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   ptrNext;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   winIdx;
   logic               found;
   logic [NUM_REQ-1:0] grantNext;
   logic [IDX_W-1:0]   idxNext;
   logic               validNext;
`ifdef HOLD_TIMEOUT_EN
   logic [7:0]         holdCount;
   logic [7:0]         holdNext;
   logic               timeoutNext;
`endif

   // Scan the request vector starting at the priority pointer and wrapping past the top,
   // so the first hit is the requester that has waited longest since its last turn.
   always_comb begin
      found  = 1'b0;
      winIdx = '0;
      cand   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ptr + IDX_W'(i);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winIdx = cand;
         end
      end
   end

   // Next-state and next-output logic. Every grant ends with a trip back through IDLE,
   // which is what produces the mandatory idle cycle between successive grants.
   always_comb begin
      stateNext = state;
      ptrNext   = ptr;
      grantNext = grant;
      idxNext   = grant_idx;
      validNext = grant_valid;
`ifdef HOLD_TIMEOUT_EN
      holdNext    = holdCount;
      timeoutNext = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               stateNext = GRANT;
               grantNext = NUM_REQ'(1) << winIdx;
               idxNext   = winIdx;
               validNext = 1'b1;
               ptrNext   = winIdx + IDX_W'(1);
`ifdef HOLD_TIMEOUT_EN
               holdNext  = 8'd0;
`endif
            end else begin
               grantNext = '0;
               idxNext   = '0;
               validNext = 1'b0;
            end
         end
         GRANT: begin
            if (!req[grant_idx]) begin
               stateNext = IDLE;
               grantNext = '0;
               idxNext   = '0;
               validNext = 1'b0;
`ifdef HOLD_TIMEOUT_EN
            end else if ({1'b0, holdCount} + 9'd1 == 9'(MAX_HOLD)) begin
               stateNext   = IDLE;
               grantNext   = '0;
               idxNext     = '0;
               validNext   = 1'b0;
               timeoutNext = 1'b1;
            end else begin
               holdNext = holdCount + 8'd1;
`endif
            end
         end
         default: begin
            stateNext = IDLE;
            grantNext = '0;
            idxNext   = '0;
            validNext = 1'b0;
         end
      endcase
   end

   // State, pointer and all grant outputs update together, keeping grant, index and valid consistent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
      end else begin
         state       <= stateNext;
         ptr         <= ptrNext;
         grant       <= grantNext;
         grant_idx   <= idxNext;
         grant_valid <= validNext;
      end
   end

`ifdef HOLD_TIMEOUT_EN
   // Hold timer; timeout is registered so it coincides with the cycle the grant disappears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdCount <= 8'd0;
         timeout   <= 1'b0;
      end else begin
         holdCount <= holdNext;
         timeout   <= timeoutNext;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus a random phase against a behavioural model.
// Define HOLD_TIMEOUT_EN here as for the RTL to exercise the hold timer.
module tb_rr_arbiter_8;

   localparam int MAX_HOLD = 16;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int testCount = 0;
   int failCount = 0;

   // Behavioural model: who owns the resource, how long, and where the next scan starts.
   bit mBusy;
   int mOwner;
   int mPtr;
   int mHold;
   bit mTimeout;

   rr_arbiter_8 dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic modelReset();
      mBusy    = 1'b0;
      mOwner   = 0;
      mPtr     = 0;
      mHold    = 0;
      mTimeout = 1'b0;
   endtask

   // One clock edge worth of arbiter rules, applied to the request vector seen at that edge.
   task automatic modelStep(input logic [7:0] r);
      mTimeout = 1'b0;
      if (!mBusy) begin
         for (int i = 0; i < 8; i++) begin
            int c;
            c = (mPtr + i) % 8;
            if (!mBusy && r[c]) begin
               mBusy  = 1'b1;
               mOwner = c;
               mPtr   = (c + 1) % 8;
               mHold  = 0;
            end
         end
      end else if (!r[mOwner]) begin
         mBusy = 1'b0;
      end else begin
`ifdef HOLD_TIMEOUT_EN
         mHold = mHold + 1;
         if (mHold == MAX_HOLD) begin
            mBusy    = 1'b0;
            mTimeout = 1'b1;
         end
`endif
      end
   endtask

   task automatic checkInt(input string tag, input int got, input int exp);
      testCount++;
      assert (got === exp) else begin
         failCount++;
         $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] expGrant;
      logic [2:0] expIdx;
      expGrant = mBusy ? (8'd1 << mOwner) : 8'd0;
      expIdx   = mBusy ? 3'(mOwner) : 3'd0;
      testCount++;
      assert (grant === expGrant) else begin
         failCount++;
         $error("[TB] FAIL %s grant got %h expected %h", tag, grant, expGrant);
      end
      testCount++;
      assert (grant_idx === expIdx) else begin
         failCount++;
         $error("[TB] FAIL %s grant_idx got %0d expected %0d", tag, grant_idx, expIdx);
      end
      testCount++;
      assert (grant_valid === mBusy) else begin
         failCount++;
         $error("[TB] FAIL %s grant_valid got %b expected %b", tag, grant_valid, mBusy);
      end
      testCount++;
      assert (timeout === mTimeout) else begin
         failCount++;
         $error("[TB] FAIL %s timeout got %b expected %b", tag, timeout, mTimeout);
      end
   endtask

   // Drive req, advance one edge, step the model and compare shortly after the edge.
   task automatic applyStimulus(input logic [7:0] r, input string tag);
      req = r;
      @(posedge clk);
      modelStep(r);
      #1;
      checkOutput(tag);
   endtask

   task automatic doReset();
      rst = 1'b1;
      req = 8'h00;
      @(posedge clk);
      #1;
      modelReset();
      checkOutput("reset");
      rst = 1'b0;
   endtask

   // Directed scenarios followed by a random phase, all in one linear sequence.
   initial begin
      logic [7:0] r;
      int         held;
      bit         prevValid;
      int         order[$];
      int         pulses;

      rst = 1'b1;
      req = 8'h00;
      modelReset();
      doReset();

      for (int i = 0; i < 10; i++) applyStimulus(8'h00, "idle_after_reset");

      applyStimulus(8'h10, "single_req4");
      checkInt("single_req4_idx", int'(grant_idx), 4);
      applyStimulus(8'h00, "single_drop");

      // Pointer now sits past requester 4, so requester 0 wins by wrapping before 3.
      applyStimulus(8'h09, "wrap_grant0");
      checkInt("wrap_first_idx", int'(grant_idx), 0);
      applyStimulus(8'h08, "wrap_release0");
      applyStimulus(8'h08, "wrap_grant3");
      checkInt("wrap_second_idx", int'(grant_idx), 3);
      applyStimulus(8'h00, "wrap_release3");

      doReset();
      held      = 0;
      prevValid = 1'b0;
      for (int cyc = 0; cyc < 200 && order.size() < 9; cyc++) begin
         r = 8'hFF;
         if (mBusy && held >= 3) r[mOwner] = 1'b0;
         applyStimulus(r, "all_req");
         if (grant_valid && !prevValid) order.push_back(int'(grant_idx));
         prevValid = grant_valid;
         held      = mBusy ? held + 1 : 0;
      end
      checkInt("order_count", order.size(), 9);
      for (int i = 0; i < 9; i++)
         checkInt("order_idx", (i < order.size()) ? order[i] : -1, i % 8);

      doReset();
      applyStimulus(8'h84, "steady_grant2");
      for (int i = 0; i < 4; i++) applyStimulus(8'h05, "steady_hold2");
      checkInt("steady_grant", int'(grant), 8'h04);
      applyStimulus(8'h00, "steady_release");

      applyStimulus(8'h20, "midrst_grant5");
      rst = 1'b1;
      #1;
      checkInt("midrst_grant", int'(grant), 0);
      checkInt("midrst_valid", int'(grant_valid), 0);
      checkInt("midrst_idx", int'(grant_idx), 0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(8'h82, "post_rst_grant");
      checkInt("post_rst_idx", int'(grant_idx), 1);
      applyStimulus(8'h00, "post_rst_release");

`ifdef HOLD_TIMEOUT_EN
      doReset();
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(8'h01, "hold_timeout");
         if (timeout === 1'b1) pulses++;
      end
      checkInt("timeout_pulses", pulses, 2);
      applyStimulus(8'h00, "hold_release");
`else
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(8'h01, "hold_forever");
         if (timeout === 1'b1) pulses++;
      end
      checkInt("no_timeout_pulses", pulses, 0);
      checkInt("held_grant", int'(grant), 8'h01);
      applyStimulus(8'h00, "hold_release");
`endif

      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom);
         if (mBusy && $urandom_range(0, 5) == 0) r[mOwner] = 1'b0;
         applyStimulus(r, "random");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
